// File: rtl/steer_pwm_ctrl.sv
// Line-following motor controller: proportional steering from row centroids, dual PWM outputs,
// lost-line search spin and a strobe watchdog.
module steer_pwm_ctrl #(
    parameter int unsigned IMG_W       = 640,
    parameter int unsigned PWM_BITS    = 8,
    parameter int unsigned BASE_DUTY   = 160,
    parameter int unsigned KP_SHIFT    = 2,
    parameter int unsigned SEARCH_DUTY = 96,
    parameter int unsigned LOST_ROWS   = 64,
    parameter int unsigned WDOG_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                cen_stb,
    input  logic [10:0]         centroid_x,
    input  logic                line_valid,
    input  logic                line_lost,
    output logic                pwm_left,
    output logic                pwm_right,
    output logic                dir_left,
    output logic                dir_right,
    output logic [PWM_BITS-1:0] duty_left,
    output logic [PWM_BITS-1:0] duty_right,
    output logic [1:0]          state,
    output logic signed [11:0]  steer_err
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StTrack  = 2'd1,
        StSearch = 2'd2,
        StStop   = 2'd3
    } state_e;

    localparam int unsigned LostW = $clog2(LOST_ROWS + 1);
    localparam int unsigned WdogW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [LostW-1:0]     LostMax  = LostW'(LOST_ROWS);
    localparam logic [WdogW-1:0]     WdogLast = WdogW'(WDOG_CYCLES - 1);
    localparam logic signed [11:0]   SetPt    = 12'(IMG_W / 2);
    localparam logic signed [13:0]   Base     = 14'(BASE_DUTY);
    localparam logic signed [13:0]   DutyMax  = 14'((2 ** PWM_BITS) - 1);
    localparam logic [PWM_BITS-1:0]  PwmMax   = '1;
    localparam logic [PWM_BITS-1:0]  SrchDuty = PWM_BITS'(SEARCH_DUTY);

    state_e               state_q, state_d;
    logic [LostW-1:0]     lost_q, lost_d, lost_inc;
    logic [WdogW-1:0]     wdog_q, wdog_d;
    logic signed [11:0]   err_q, err_d;
    logic [PWM_BITS-1:0]  pwm_cnt_q;
    logic [PWM_BITS-1:0]  pend_l_q, pend_r_q, pend_l_d, pend_r_d;
    logic                 pend_dl_q, pend_dr_q, pend_dl_d, pend_dr_d;
    logic signed [13:0]   err_ext, delta, sum_l, sum_r;
    logic                 run_q, run_d;

    assign state     = state_q;
    assign steer_err = err_q;
    assign lost_inc  = lost_q + 1'b1;
    assign run_q     = (state_q == StTrack) || (state_q == StSearch);
    assign run_d     = (state_d == StTrack) || (state_d == StSearch);

    function automatic logic [PWM_BITS-1:0] clamp_duty(input logic signed [13:0] v);
        if (v < 0) begin
            return '0;
        end else if (v > DutyMax) begin
            return '1;
        end else begin
            return v[PWM_BITS-1:0];
        end
    endfunction

    always_comb begin
        state_d = state_q;
        lost_d  = lost_q;
        wdog_d  = wdog_q;
        err_d   = err_q;
        if (!enable) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: state_d = StTrack;
                StTrack, StSearch: begin
                    wdog_d = (wdog_q == WdogLast) ? wdog_q : wdog_q + 1'b1;
                    if (cen_stb) begin
                        wdog_d = '0;
                        if (line_valid) begin
                            err_d   = $signed({1'b0, centroid_x}) - SetPt;
                            lost_d  = '0;
                            state_d = StTrack;
                        end else if (line_lost) begin
                            if (lost_q != LostMax) begin
                                lost_d = lost_inc;
                            end
                            if (state_q == StTrack && lost_inc == LostMax) begin
                                state_d = StSearch;
                            end
                        end
                    end else if (wdog_q == WdogLast) begin
                        state_d = StStop;
                    end
                end
                default: state_d = StStop;
            endcase
        end
        if (state_d == StIdle) begin
            lost_d = '0;
            wdog_d = '0;
        end
    end

    // Pending duty follows the registered error, one clock behind it.
    always_comb begin
        err_ext   = {{2{err_q[11]}}, err_q};
        delta     = err_ext >>> KP_SHIFT;
        sum_l     = Base + delta;
        sum_r     = Base - delta;
        pend_l_d  = '0;
        pend_r_d  = '0;
        pend_dl_d = 1'b0;
        pend_dr_d = 1'b0;
        if (state_q == StTrack) begin
            pend_l_d  = clamp_duty(sum_l);
            pend_r_d  = clamp_duty(sum_r);
            pend_dl_d = 1'b1;
            pend_dr_d = 1'b1;
        end else if (state_q == StSearch) begin
            pend_l_d  = SrchDuty;
            pend_r_d  = SrchDuty;
            pend_dl_d = ~err_q[11];
            pend_dr_d = err_q[11];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            lost_q     <= '0;
            wdog_q     <= '0;
            err_q      <= '0;
            pend_l_q   <= '0;
            pend_r_q   <= '0;
            pend_dl_q  <= 1'b0;
            pend_dr_q  <= 1'b0;
            pwm_cnt_q  <= '0;
            duty_left  <= '0;
            duty_right <= '0;
            dir_left   <= 1'b0;
            dir_right  <= 1'b0;
            pwm_left   <= 1'b0;
            pwm_right  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lost_q    <= lost_d;
            wdog_q    <= wdog_d;
            err_q     <= err_d;
            pend_l_q  <= pend_l_d;
            pend_r_q  <= pend_r_d;
            pend_dl_q <= pend_dl_d;
            pend_dr_q <= pend_dr_d;
            if (run_q && run_d) begin
                pwm_cnt_q <= pwm_cnt_q + 1'b1;
                // Duties swap only at period end so each period uses one consistent duty.
                if (pwm_cnt_q == PwmMax) begin
                    duty_left  <= pend_l_q;
                    duty_right <= pend_r_q;
                    dir_left   <= pend_dl_q;
                    dir_right  <= pend_dr_q;
                end
                pwm_left  <= pwm_cnt_q < duty_left;
                pwm_right <= pwm_cnt_q < duty_right;
            end else begin
                pwm_cnt_q  <= '0;
                duty_left  <= '0;
                duty_right <= '0;
                dir_left   <= 1'b0;
                dir_right  <= 1'b0;
                pwm_left   <= 1'b0;
                pwm_right  <= 1'b0;
            end
        end
    end

endmodule
